// File: rtl/stopwatch_key_ctrl.sv
// Key conditioning and run/lap/pause sequencing for the stopwatch datapath.
// Synchronizes and debounces the two active-low keys, then drives the tick gate, counter clear and display hold.
module stopwatch_key_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 50_000_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [1:0] KEY,
    output logic       run_n,
    output logic       clear,
    output logic       lap_hold,
    output logic [1:0] state
);

    // state | meaning
    // IDLE  | stopped at zero (or stopped awaiting clear), not counting
    // RUN   | counting, display live
    // LAP   | counting, display frozen
    // PAUSE | stopped, display shows paused time
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_LAP   = 2'b10;
    localparam logic [1:0] S_PAUSE = 2'b11;

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int LW = $clog2(LONG_PRESS_CYCLES) + 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LP_LAST = LW'(LONG_PRESS_CYCLES - 1);
    localparam logic [LW-1:0] LP_MAX  = LW'(LONG_PRESS_CYCLES);

    logic [1:0]    sync1, sync2;
    logic [1:0]    deb, deb_d;
    logic [DW-1:0] db_cnt [2];
    logic [LW-1:0] hold_cnt;
    logic          long_done;
    logic          press0, rel1, long1;
    logic [1:0]    nxt_state;
    logic          clr_nxt;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
        end
    end

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            deb       <= 2'b11;
            deb_d     <= 2'b11;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            deb_d <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        deb[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // long_done stays set until the key is back up for a full cycle so the release edge is swallowed.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hold_cnt  <= '0;
            long_done <= 1'b0;
            press0    <= 1'b0;
            rel1      <= 1'b0;
            long1     <= 1'b0;
        end else begin
            press0 <= deb_d[0] & ~deb[0];
            rel1   <= ~deb_d[1] & deb[1] & ~long_done;
            long1  <= ~deb[1] && (hold_cnt == LP_LAST);
            if (deb[1]) begin
                hold_cnt <= '0;
            end else if (hold_cnt != LP_MAX) begin
                hold_cnt <= hold_cnt + LW'(1);
            end
            if (~deb[1] && (hold_cnt == LP_LAST)) begin
                long_done <= 1'b1;
            end else if (deb[1] && deb_d[1]) begin
                long_done <= 1'b0;
            end
        end
    end

    always_comb begin
        nxt_state = state;
        clr_nxt   = 1'b0;
        if (long1) begin
            nxt_state = S_IDLE;
            clr_nxt   = 1'b1;
        end else if (press0) begin
            case (state)
                S_IDLE:  nxt_state = S_RUN;
                S_RUN:   nxt_state = S_PAUSE;
                S_LAP:   nxt_state = S_PAUSE;
                S_PAUSE: nxt_state = S_RUN;
                default: nxt_state = S_IDLE;
            endcase
        end else if (rel1) begin
            case (state)
                S_IDLE: begin
                    nxt_state = S_IDLE;
                    clr_nxt   = 1'b1;
                end
                S_RUN:   nxt_state = S_LAP;
                S_LAP:   nxt_state = S_RUN;
                S_PAUSE: begin
                    nxt_state = S_IDLE;
                    clr_nxt   = 1'b1;
                end
                default: nxt_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= S_IDLE;
            clear    <= 1'b0;
            run_n    <= 1'b1;
            lap_hold <= 1'b0;
        end else begin
            state    <= nxt_state;
            clear    <= clr_nxt;
            run_n    <= ~((nxt_state == S_RUN) || (nxt_state == S_LAP));
            lap_hold <= (nxt_state == S_LAP);
        end
    end

endmodule

// File: tb/tb_stopwatch_key_ctrl.sv
// Directed bench for stopwatch_key_ctrl with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20.
// Each table row drives KEY for a number of cycles, then checks state, outputs and clear pulse count.
module tb_stopwatch_key_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] key;
    logic       run_n, clear, lap_hold;
    logic [1:0] state;

    int n_vec = 0;
    int n_bad = 0;
    int clr_cnt;

    typedef struct {
        logic [1:0] key;
        int         cycles;
        logic [1:0] exp_state;
        logic       exp_run_n;
        logic       exp_lap;
        int         exp_clears;
    } vec_t;

    vec_t tbl[$];

    stopwatch_key_ctrl #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(20)
    ) dut (
        .CLOCK_50(clk),
        .reset   (reset),
        .KEY     (key),
        .run_n   (run_n),
        .clear   (clear),
        .lap_hold(lap_hold),
        .state   (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive KEY just after an edge, then advance n edges sampling 1 time unit past each.
    task automatic apply(input logic [1:0] k, input int n);
        key = k;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (clear) clr_cnt++;
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] s, input logic rn, input logic lh);
        check({tag, " state"}, int'(state), int'(s));
        check({tag, " run_n"}, int'(run_n), int'(rn));
        check({tag, " lap_hold"}, int'(lap_hold), int'(lh));
    endtask

    initial begin
        // {key, cycles, state, run_n, lap_hold, clears}; starts in RUN with keys released
        tbl.push_back('{2'b10, 10, 2'b11, 1'b1, 1'b0, 0});
        tbl.push_back('{2'b11, 10, 2'b11, 1'b1, 1'b0, 0});
        tbl.push_back('{2'b01,  8, 2'b11, 1'b1, 1'b0, 0});
        tbl.push_back('{2'b11, 10, 2'b00, 1'b1, 1'b0, 1});
        for (int r = 0; r < 5; r++) begin
            tbl.push_back('{2'b10, 3, 2'b00, 1'b1, 1'b0, 0});
            tbl.push_back('{2'b11, 2, 2'b00, 1'b1, 1'b0, 0});
        end
        tbl.push_back('{2'b11, 10, 2'b00, 1'b1, 1'b0, 0});
        tbl.push_back('{2'b10,  4, 2'b00, 1'b1, 1'b0, 0});
        tbl.push_back('{2'b11, 10, 2'b01, 1'b0, 1'b0, 0});
        tbl.push_back('{2'b01,  8, 2'b01, 1'b0, 1'b0, 0});
        tbl.push_back('{2'b11, 10, 2'b10, 1'b0, 1'b1, 0});
        tbl.push_back('{2'b01,  8, 2'b10, 1'b0, 1'b1, 0});
        tbl.push_back('{2'b11, 10, 2'b01, 1'b0, 1'b0, 0});
        tbl.push_back('{2'b01,  8, 2'b01, 1'b0, 1'b0, 0});
        tbl.push_back('{2'b11, 10, 2'b10, 1'b0, 1'b1, 0});
        tbl.push_back('{2'b10, 10, 2'b11, 1'b1, 1'b0, 0});
        tbl.push_back('{2'b11, 10, 2'b11, 1'b1, 1'b0, 0});
        tbl.push_back('{2'b10, 10, 2'b01, 1'b0, 1'b0, 0});
        tbl.push_back('{2'b11, 10, 2'b01, 1'b0, 1'b0, 0});
        tbl.push_back('{2'b01, 40, 2'b00, 1'b1, 1'b0, 1});
        tbl.push_back('{2'b11, 10, 2'b00, 1'b1, 1'b0, 0});
        tbl.push_back('{2'b10, 10, 2'b01, 1'b0, 1'b0, 0});
        tbl.push_back('{2'b11, 10, 2'b01, 1'b0, 1'b0, 0});
        // KEY[1] held, then released in the same cycle KEY[0] is pressed
        tbl.push_back('{2'b01,  8, 2'b01, 1'b0, 1'b0, 0});
        tbl.push_back('{2'b10, 10, 2'b11, 1'b1, 1'b0, 0});
        tbl.push_back('{2'b11, 10, 2'b11, 1'b1, 1'b0, 0});

        reset   = 1'b1;
        key     = 2'b11;
        clr_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 2'b00, 1'b1, 1'b0);
        check("reset clear", int'(clear), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_outs("post_reset", 2'b00, 1'b1, 1'b0);
        check("post_reset clear", int'(clear), 0);

        // Raw edge to output change is DEBOUNCE_CYCLES + 4 = 8 edges.
        apply(2'b10, 7);
        check_outs("latency_7", 2'b00, 1'b1, 1'b0);
        apply(2'b10, 1);
        check_outs("latency_8", 2'b01, 1'b0, 1'b0);
        apply(2'b10, 2);
        apply(2'b11, 10);
        check_outs("start_release", 2'b01, 1'b0, 1'b0);
        check("start clears", clr_cnt, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            clr_cnt = 0;
            apply(tbl[i].key, tbl[i].cycles);
            check_outs($sformatf("row%0d", i), tbl[i].exp_state, tbl[i].exp_run_n, tbl[i].exp_lap);
            check($sformatf("row%0d clears", i), clr_cnt, tbl[i].exp_clears);
        end

        // Reset during a held press: the key must be re-detected as a fresh press.
        apply(2'b10, 10);
        check_outs("midpress_run", 2'b01, 1'b0, 1'b0);
        reset = 1'b1;
        apply(2'b10, 2);
        check_outs("midpress_reset", 2'b00, 1'b1, 1'b0);
        reset   = 1'b0;
        clr_cnt = 0;
        apply(2'b10, 7);
        check_outs("midpress_7", 2'b00, 1'b1, 1'b0);
        apply(2'b10, 1);
        check_outs("midpress_8", 2'b01, 1'b0, 1'b0);
        apply(2'b11, 10);
        check("midpress clears", clr_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
